signed_narrow: RTL
==================

SIGNED_NARROW -- requirements
Module: signed_narrow

Interface
REQ-001 SHALL have parameter OVF_CNT_W, default 16, which sets the width of the overflow event counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the source presents an operand.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept an operand this cycle.
REQ-006 SHALL have port data_in, input, 64 bits: the signed operand.
REQ-007 SHALL have port size_in, input, 2 bits: target width; 00=byte(8), 01=half(16), 10=word(32), 11=dword(64).
REQ-008 SHALL have port out_valid, output, 1 bit: the result at the head of the buffer is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the sink takes the head result.
REQ-010 SHALL have port data_out, output, 64 bits: the narrowed result; bits above the target width are zero.
REQ-011 SHALL have port size_out, output, 2 bits: size_in captured with the head result.
REQ-012 SHALL have port overflow, output, 1 bit: the head operand does not fit the target width as a signed value.
REQ-013 SHALL have port ovf_count, output, OVF_CNT_W bits: count of accepted operands that overflowed.

Function
REQ-014 SHALL accept an operand in cycle N when in_valid and in_ready are both high in that cycle.
REQ-015 SHALL compute the result combinationally from data_in and size_in and write it into a 2-entry FIFO at the cycle-N edge.
REQ-016 SHALL hold the result at the FIFO head so that out_valid is high in cycle N+1 when the FIFO was empty: latency 1 cycle.
REQ-017 SHALL sustain a throughput of 1 operand per cycle while out_ready is held high.
REQ-018 SHALL set overflow for a target width W<64 iff data_in[63:W-1] are not all equal.
REQ-019 SHALL never set overflow for the dword target.
REQ-020 SHALL, when overflow is clear, drive data_out[W-1:0]=data_in[W-1:0] with data_out[63:W]=0.
REQ-021 SHALL use default overflow behaviour that truncates exactly as REQ-020 (plain truncation).
REQ-022 SHALL drive in_ready = (count<2), registered with no combinational path from out_ready.
REQ-023 SHALL block a push when the FIFO is full, even if a pop occurs in the same cycle.
REQ-024 SHALL raise out_valid = (count!=0) and pop on the rising edge when out_valid and out_ready are both high.
REQ-025 SHALL, on a simultaneous push and pop with 1 entry, leave count at 1 and present the new entry at the head in the next cycle.
REQ-026 SHALL use 1-bit read and write pointers that wrap from 1 to 0; the count range is 0..2.
REQ-027 SHALL hold the head data, size_out and overflow stable while out_valid is high and out_ready is low.
REQ-028 SHALL increment ovf_count by 1 for each accepted operand with overflow set.
REQ-029 SHALL saturate ovf_count at all-ones and never wrap it.

Reset
REQ-030 SHALL, on reset high at a clk edge, clear count, both pointers and ovf_count.
REQ-031 SHALL, after reset, give out_valid=0 and in_ready=1, with data_out, size_out and overflow all at 0.
REQ-032 SHALL discard in-flight FIFO entries when reset is asserted mid-operation.
REQ-033 SHALL, when reset is asserted mid-operation, ignore in the same cycle any handshake on in_valid or out_ready.

Configuration
REQ-034 SHALL, with SIGNED_NARROW_SAT_EN defined, saturate on overflow: data_in[63]=0 gives data_out = 2^(W-1)-1, and data_in[63]=1 gives data_out[W-1:0] = 1 followed by W-1 zeros, with upper bits 0.
REQ-035 SHALL, with SIGNED_NARROW_SAT_EN defined, still assert overflow and still count the overflow in ovf_count.
REQ-036 SHALL, without SIGNED_NARROW_SAT_EN, produce truncation only as in REQ-021.

Verification
REQ-037 SHALL verify in-range byte: data_in=64'hFFFF_FFFF_FFFF_FF80, size=00 -> next cycle data_out=64'h80, overflow=0.
REQ-038 SHALL verify out-of-range byte: data_in=64'h0000_0000_0000_0080, size=00 -> overflow=1 and ovf_count=1; data_out=64'h80 without the macro, 64'h7F with SIGNED_NARROW_SAT_EN.
REQ-039 SHALL verify negative word overflow: data_in=64'h8000_0000_0000_0000, size=10 -> overflow=1; data_out=0 without the macro, 64'h8000_0000 with the macro.
REQ-040 SHALL verify backpressure: out_ready=0 with 3 back-to-back operands -> in_ready falls after 2 accepts, the third is held, and the outputs stay stable; out_ready=1 -> results drain in order.
REQ-041 SHALL verify a full stream: out_ready=1 with 10 consecutive operands -> 10 results on 10 consecutive cycles starting 1 cycle after the first accept.
REQ-042 SHALL verify reset mid-operation: reset pulse with 2 entries buffered -> next cycle out_valid=0, in_ready=1, ovf_count=0.

Source files
------------

// File: rtl/signed_narrow.sv
// Signed narrowing unit: checks a 64-bit operand against a byte/half/word/dword target
// and queues the result in a 2-entry FIFO. Define SIGNED_NARROW_SAT_EN to saturate on overflow.
module signed_narrow #(
    parameter int OVF_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [63:0]          data_in,
    input  logic [1:0]           size_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          data_out,
    output logic [1:0]           size_out,
    output logic                 overflow,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    logic [63:0]          r_data [2];
    logic [1:0]           r_size [2];
    logic                 r_ovf  [2];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_count;
    logic                 r_in_ready;
    logic [OVF_CNT_W-1:0] r_ovf_cnt;

    logic                 w_ovf;
    logic [63:0]          w_trunc;
    logic [63:0]          w_result;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_count_nxt;

    // Overflow iff the bits from the target sign bit upward are not all equal.
    always_comb begin
        w_ovf   = 1'b0;
        w_trunc = data_in;
        unique case (size_in)
            2'b00: begin
                w_ovf   = !((&data_in[63:7]) || !(|data_in[63:7]));
                w_trunc = {56'd0, data_in[7:0]};
            end
            2'b01: begin
                w_ovf   = !((&data_in[63:15]) || !(|data_in[63:15]));
                w_trunc = {48'd0, data_in[15:0]};
            end
            2'b10: begin
                w_ovf   = !((&data_in[63:31]) || !(|data_in[63:31]));
                w_trunc = {32'd0, data_in[31:0]};
            end
            2'b11: begin
                w_ovf   = 1'b0;
                w_trunc = data_in;
            end
        endcase
    end

`ifdef SIGNED_NARROW_SAT_EN
    logic [63:0] w_sat;

    always_comb begin
        w_sat = data_in;
        unique case (size_in)
            2'b00: w_sat = data_in[63] ? 64'h80 : 64'h7F;
            2'b01: w_sat = data_in[63] ? 64'h8000 : 64'h7FFF;
            2'b10: w_sat = data_in[63] ? 64'h8000_0000 : 64'h7FFF_FFFF;
            2'b11: w_sat = data_in;
        endcase
        w_result = w_ovf ? w_sat : w_trunc;
    end
`else
    assign w_result = w_trunc;
`endif

    assign w_push      = in_valid && r_in_ready;
    assign w_pop       = (r_count != 2'd0) && out_ready;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data[0]  <= '0;
            r_data[1]  <= '0;
            r_size[0]  <= '0;
            r_size[1]  <= '0;
            r_ovf[0]   <= 1'b0;
            r_ovf[1]   <= 1'b0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wptr] <= w_result;
                r_size[r_wptr] <= size_in;
                r_ovf[r_wptr]  <= w_ovf;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count    <= w_count_nxt;
            // in_ready looks only at the next count, so out_ready never reaches it combinationally.
            r_in_ready <= (w_count_nxt != 2'd2);
            if (w_push && w_ovf && (r_ovf_cnt != {OVF_CNT_W{1'b1}})) begin
                r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign data_out  = r_data[r_rptr];
    assign size_out  = r_size[r_rptr];
    assign overflow  = r_ovf[r_rptr];
    assign ovf_count = r_ovf_cnt;

endmodule
